generador_seg: RTL and testbench
================================

Name: generador_seg

Overview:
- Seconds stage of the stopwatch; sits directly upstream of the minutes counter.
- Divides the system clock down to a 1 Hz enable and runs a start/pause/clear FSM.
- Counts seconds 00–59 in BCD.
- Emits a one-cycle `min_tick` on each 59→00 wrap; the minutes stage consumes this pulse as its advance event.

Parameters:
- CYCLES_PER_SEC, 50_000_000, clk cycles per counted second. Must be ≥ 2; set to 4 in simulation.
- PRESC_W, $clog2(CYCLES_PER_SEC), prescaler register width. Derived; do not override.

Ports:
- clk  input  1  system clock. Single clock domain; all logic on posedge clk.
- reset  input  1  synchronous, active-high reset.
- start_stop  input  1  one-cycle pulse (already debounced/edge-detected). Toggles run/pause.
- clear  input  1  one-cycle pulse. Returns to zero and stops.
- sec_low  output  4  BCD seconds units, 0–9.
- sec_high  output  4  BCD seconds tens, 0–5.
- min_tick  output  1  one-cycle pulse on the 59→00 wrap; feeds the minutes stage.
- running  output  1  high while in state RUN.

Behaviour:
- Reset (sampled on posedge clk while reset=1):
  - state←IDLE, prescaler←0, sec_low←0, sec_high←0, min_tick←0, running←0.
  - Reset overrides all other inputs.
- States: IDLE (zeroed, stopped), RUN, PAUSE. `running` is decoded from the state register (state==RUN), so it has no extra latency.
- IDLE:
  - start_stop → RUN.
  - clear → stay IDLE (counters already zero).
- RUN:
  - prescaler increments every cycle.
  - start_stop → PAUSE.
  - clear → IDLE with prescaler, sec_low and sec_high zeroed.
- PAUSE:
  - prescaler and digits hold.
  - start_stop → RUN; resumes from the held prescaler value, no restart of the partial second.
  - clear → IDLE, all zeroed.
- clear and start_stop in the same cycle: clear wins in every state.
- Terminal count (RUN and prescaler==CYCLES_PER_SEC-1), on that edge:
  - prescaler←0 and the seconds advance once.
  - If start_stop is also asserted, the advance still happens, then state←PAUSE.
  - If clear is also asserted, clear wins: no advance, no min_tick.
- Seconds advance:
  - sec_low<9: sec_low+1.
  - sec_low==9: sec_low←0, then sec_high<5: sec_high+1; sec_high==5: sec_high←0.
- min_tick:
  - Registered. Driven to 1 on exactly the edge where 5:9 wraps to 0:0, so it is high in the same cycle the outputs first show 00.
  - Driven to 0 on every other edge.
  - Never high for two consecutive cycles.
- Latency:
  - With CYCLES_PER_SEC=N and start_stop in cycle 0, the first increment is visible after N edges in RUN.
  - The first min_tick comes 60·N edges after start.
- Digit codes above 9/5 are unreachable; no recovery logic required.

Optional Feature:
- Macro: GENERADOR_SEG_LAP_EN.
- Defined:
  - Adds input `lap` (1-bit pulse).
  - The first lap pulse freezes `sec_low`/`sec_high` at the current values (lap latch registers).
  - The internal count, `min_tick` and the FSM keep running.
  - The next lap pulse releases the freeze; outputs follow the live count on the following cycle.
  - clear or reset also releases the freeze.
  - lap is ignored in IDLE.
- Undefined: the `lap` port and the latch registers are absent; outputs always follow the live count.

Decomposition:
- Shared package `cronometro_pkg`, used by this block and future hours/centiseconds stages:
  - state enum {IDLE, RUN, PAUSE} (2-bit).
  - constants BCD_LOW_MAX=9, SEC_HIGH_MAX=5.
- One sub-module, `divisor_tick`:
  - Parameter CYCLES_PER_SEC.
  - Inputs clk, reset, enable, clr.
  - Output tick, high on the terminal cycle.
  - The seconds FSM and BCD counters stay in generador_seg.

Test Plan (CYCLES_PER_SEC=4):
- Reset then start_stop at cycle 0 → running=1 next cycle; sec_low=1 after 4 edges; sec_high:sec_low=1:0 after 40 edges.
- Run 240 edges from start → outputs 0:0 and min_tick=1 for exactly one cycle at edge 240; zero at 239 and 241.
- start_stop at edge 6 (prescaler=2), hold 20 cycles, start_stop again → digits frozen at 0:1 during pause; next increment arrives 2 edges after resume, not 4.
- clear and start_stop together in RUN at 3:7 → IDLE, outputs 0:0, running=0, min_tick=0.
- Terminal-count cycle coincides with start_stop at 5:9 → outputs 0:0, min_tick=1, state PAUSE; with clear instead → 0:0, min_tick=0, IDLE.
- Reset asserted mid-run at 4:2 with a start_stop pulse the same cycle → all outputs 0, IDLE, no min_tick. With GENERADOR_SEG_LAP_EN: lap at 0:5 holds outputs at 0:5 while the count reaches 1:2; second lap → outputs 1:2 next cycle.

Source files
------------

// File: rtl/cronometro_pkg.sv
// Shared stopwatch definitions: FSM state encoding and BCD digit limits,
// reused by the seconds, minutes, hours and centiseconds stages.
package cronometro_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_LOW_MAX  = 4'd9;
    localparam logic [3:0] SEC_HIGH_MAX = 4'd5;

endpackage

// File: rtl/generador_seg_divisor_tick.sv
// Prescaler for the seconds stage: counts enabled cycles and flags the
// terminal cycle of each CYCLES_PER_SEC period with tick.
module divisor_tick #(
    parameter int CYCLES_PER_SEC = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clr,
    output logic tick
);

    localparam int PRESC_W = $clog2(CYCLES_PER_SEC);
    localparam logic [PRESC_W-1:0] TERMINAL = PRESC_W'(CYCLES_PER_SEC - 1);

    logic [PRESC_W-1:0] presc;

    assign tick = enable && (presc == TERMINAL);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            presc <= '0;
        end else if (enable) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

endmodule

// File: rtl/generador_seg.sv
// Stopwatch seconds stage: start/pause/clear FSM, BCD 00-59 counter and
// min_tick on the 59->00 wrap. Optional lap freeze via GENERADOR_SEG_LAP_EN.
module generador_seg
    import cronometro_pkg::*;
#(
    parameter int CYCLES_PER_SEC = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] sec_low,
    output logic [3:0] sec_high,
    output logic       min_tick,
    output logic       running
`ifdef GENERADOR_SEG_LAP_EN
    ,
    input  logic       lap
`endif
);

    state_t     state_q, state_d;
    logic [3:0] cnt_low, cnt_high, low_d, high_d;
    logic       tick_d;
    logic       sec_tick;

    assign running = (state_q == RUN);

    divisor_tick #(
        .CYCLES_PER_SEC(CYCLES_PER_SEC)
    ) u_divisor (
        .clk   (clk),
        .reset (reset),
        .enable(running),
        .clr   (clear),
        .tick  (sec_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_low  <= '0;
            cnt_high <= '0;
            min_tick <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_low  <= low_d;
            cnt_high <= high_d;
            min_tick <= tick_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        low_d   = cnt_low;
        high_d  = cnt_high;
        tick_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!clear && start_stop) state_d = RUN;
            end
            RUN: begin
                if (clear) begin
                    state_d = IDLE;
                    low_d   = '0;
                    high_d  = '0;
                end else begin
                    // The terminal-count advance still happens when start_stop pauses on the same edge.
                    if (sec_tick) begin
                        if (cnt_low == BCD_LOW_MAX) begin
                            low_d = '0;
                            if (cnt_high == SEC_HIGH_MAX) begin
                                high_d = '0;
                                tick_d = 1'b1;
                            end else begin
                                high_d = cnt_high + 4'd1;
                            end
                        end else begin
                            low_d = cnt_low + 4'd1;
                        end
                    end
                    if (start_stop) state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (clear) begin
                    state_d = IDLE;
                    low_d   = '0;
                    high_d  = '0;
                end else if (start_stop) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef GENERADOR_SEG_LAP_EN
    logic       lap_frozen;
    logic [3:0] lap_low, lap_high;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lap_frozen <= 1'b0;
            lap_low    <= '0;
            lap_high   <= '0;
        end else if (lap && state_q != IDLE) begin
            lap_frozen <= !lap_frozen;
            if (!lap_frozen) begin
                lap_low  <= cnt_low;
                lap_high <= cnt_high;
            end
        end
    end

    assign sec_low  = lap_frozen ? lap_low  : cnt_low;
    assign sec_high = lap_frozen ? lap_high : cnt_high;
`else
    assign sec_low  = cnt_low;
    assign sec_high = cnt_high;
`endif

endmodule

// File: tb/tb_generador_seg.sv
// Bench for generador_seg (CYCLES_PER_SEC=4): directed scenarios with literal
// expectations plus randomized pulses, all checked against a seconds-count model.
module tb_generador_seg;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic       lap = 1'b0;
    logic [3:0] sec_low, sec_high;
    logic       min_tick, running;

    always #5 clk = ~clk;

    generador_seg #(
        .CYCLES_PER_SEC(N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start_stop(start_stop),
        .clear     (clear),
        .sec_low   (sec_low),
        .sec_high  (sec_high),
        .min_tick  (min_tick),
        .running   (running)
`ifdef GENERADOR_SEG_LAP_EN
        ,
        .lap       (lap)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: mode 0=stopped/zeroed, 1=counting, 2=paused; elapsed time kept as
    // a plain seconds number 0..59 plus cycles into the current second.
    int m_mode = 0, m_presc = 0, m_secs = 0, m_tick = 0, m_lap = 0;
    bit m_frozen = 1'b0;
    bit armed = 1'b0;

    always @(posedge clk) begin : model
        int mode, presc, secs, tk, lapv;
        bit fr;
        mode = m_mode; presc = m_presc; secs = m_secs; lapv = m_lap; fr = m_frozen;
        tk = 0;
        if (reset) begin
            mode = 0; presc = 0; secs = 0; fr = 1'b0; lapv = 0;
        end else begin
`ifdef GENERADOR_SEG_LAP_EN
            if (clear) fr = 1'b0;
            else if (lap && m_mode != 0) begin
                if (!fr) lapv = m_secs;
                fr = !fr;
            end
`endif
            if (clear) begin
                mode = 0; presc = 0; secs = 0;
            end else if (m_mode == 0) begin
                if (start_stop) mode = 1;
            end else if (m_mode == 1) begin
                if (presc == N - 1) begin
                    presc = 0;
                    secs = (secs + 1) % 60;
                    if (secs == 0) tk = 1;
                end else begin
                    presc++;
                end
                if (start_stop) mode = 2;
            end else begin
                if (start_stop) mode = 1;
            end
        end
        m_mode   <= mode;
        m_presc  <= presc;
        m_secs   <= secs;
        m_tick   <= tk;
        m_lap    <= lapv;
        m_frozen <= fr;
    end

    always @(negedge clk) begin
        if (armed) begin
            int shown;
            shown = m_frozen ? m_lap : m_secs;
            check("model_sec_low",  32'(sec_low),  32'(shown % 10));
            check("model_sec_high", 32'(sec_high), 32'(shown / 10));
            check("model_min_tick", 32'(min_tick), 32'(m_tick));
            check("model_running",  32'(running),  32'(m_mode == 1));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_stop = 1'b1; step(1); start_stop = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; step(1); clear = 1'b0;
    endtask

    task automatic check_out(input string name, input int hi, input int lo, input int mt, input int run);
        check({name, "_hi"},  32'(sec_high), 32'(hi));
        check({name, "_lo"},  32'(sec_low),  32'(lo));
        check({name, "_mt"},  32'(min_tick), 32'(mt));
        check({name, "_run"}, 32'(running),  32'(run));
    endtask

    initial begin
        step(2);
        armed = 1'b1;
        check_out("reset", 0, 0, 0, 0);
        reset = 1'b0;

        // Start and first increments; wrap at edge 240.
        pulse_start();
        check_out("start", 0, 0, 0, 1);
        step(4);   check_out("edge4", 0, 1, 0, 1);
        step(36);  check_out("edge40", 1, 0, 0, 1);
        step(199); check_out("edge239", 5, 9, 0, 1);
        step(1);   check_out("edge240", 0, 0, 1, 1);
        step(1);   check_out("edge241", 0, 0, 0, 1);

        // Pause at prescaler 2 keeps the partial second.
        pulse_clear();
        check_out("clr_run", 0, 0, 0, 0);
        pulse_start();
        step(5);
        start_stop = 1'b1; step(1); start_stop = 1'b0;
        check_out("paused", 0, 1, 0, 0);
        step(20);  check_out("pause_hold", 0, 1, 0, 0);
        pulse_start();
        check_out("resume", 0, 1, 0, 1);
        step(1);   check_out("resume1", 0, 1, 0, 1);
        step(1);   check_out("resume2", 0, 2, 0, 1);

        // clear + start_stop together at 3:7.
        pulse_clear();
        pulse_start();
        step(148); check_out("at37", 3, 7, 0, 1);
        clear = 1'b1; start_stop = 1'b1; step(1); clear = 1'b0; start_stop = 1'b0;
        check_out("clr_and_ss", 0, 0, 0, 0);

        // Terminal count with start_stop at 5:9, then with clear.
        pulse_start();
        step(239); check_out("tc_pre", 5, 9, 0, 1);
        start_stop = 1'b1; step(1); start_stop = 1'b0;
        check_out("tc_ss", 0, 0, 1, 0);
        step(3);   check_out("tc_ss_hold", 0, 0, 0, 0);
        pulse_clear();
        pulse_start();
        step(239);
        clear = 1'b1; step(1); clear = 1'b0;
        check_out("tc_clr", 0, 0, 0, 0);

        // Reset mid-run at 4:2 with start_stop.
        pulse_start();
        step(168); check_out("at42", 4, 2, 0, 1);
        reset = 1'b1; start_stop = 1'b1; step(1); reset = 1'b0; start_stop = 1'b0;
        check_out("rst_mid", 0, 0, 0, 0);
        step(2);   check_out("rst_idle", 0, 0, 0, 0);

`ifdef GENERADOR_SEG_LAP_EN
        pulse_start();
        step(20);  check_out("lap_at05", 0, 5, 0, 1);
        lap = 1'b1; step(1); lap = 1'b0;
        step(27);  check_out("lap_hold", 0, 5, 0, 1);
        lap = 1'b1; step(1); lap = 1'b0;
        check_out("lap_release", 1, 2, 0, 1);
        pulse_clear();
`endif

        // Randomized pulses, alternating busy and sparse phases.
        for (int i = 0; i < 4000; i++) begin
            int rate;
            rate = ((i / 500) % 2 == 1) ? 200 : 8;
            start_stop = ($urandom_range(0, rate - 1) == 0);
            clear      = ($urandom_range(0, 4 * rate) == 0);
            reset      = ($urandom_range(0, 999) == 0);
`ifdef GENERADOR_SEG_LAP_EN
            lap        = ($urandom_range(0, 39) == 0);
`endif
            step(1);
        end
        start_stop = 1'b0; clear = 1'b0; reset = 1'b0; lap = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
